// File: rtl/perf_report_pkg.sv
// perf_report_pkg: shared definitions for the performance-counter UART reporter.
//   tx_state_e    : byte serialiser state encoding
//   SYNC_BYTE     : first byte of every report frame
//   FRAME_BYTES   : bytes per frame (sync + 4 cycle_count + 4 instr_retired)
//   BITS_PER_BYTE : data bits per serial character
//   frame_byte()  : byte mux selecting frame byte <idx> from the snapshots
package perf_report_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam logic [7:0]  SYNC_BYTE     = 8'hA5;
  localparam int unsigned FRAME_BYTES   = 9;
  localparam int unsigned BITS_PER_BYTE = 8;

  // Both counters go out least-significant byte first.
  function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                            input logic [31:0] cyc,
                                            input logic [31:0] ins);
    logic [7:0] b;
    case (idx)
      4'd0:    b = SYNC_BYTE;
      4'd1:    b = cyc[7:0];
      4'd2:    b = cyc[15:8];
      4'd3:    b = cyc[23:16];
      4'd4:    b = cyc[31:24];
      4'd5:    b = ins[7:0];
      4'd6:    b = ins[15:8];
      4'd7:    b = ins[23:16];
      4'd8:    b = ins[31:24];
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/perf_uart_reporter_if.sv
// perf_uart_reporter_if: byte valid/ready handshake between the frame
// sequencer and the byte serialiser.
//   valid : a byte is offered on data
//   data  : byte to serialise
//   ready : serialiser takes the byte in this cycle if valid is high
interface perf_uart_reporter_if;
  logic       valid;
  logic [7:0] data;
  logic       ready;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: serialises one byte per handshake as start(0), 8 data bits
// LSB first, stop(1), each bit held CLKS_PER_BIT clocks.
//   clk, rst : clock, synchronous active-high reset
//   bus      : byte handshake (slave side)
//   tx       : registered serial output, idles high
// ready is raised in IDLE and in the last cycle of a stop bit, so a byte
// offered then starts its start bit with no idle gap.
module uart_tx_byte
  import perf_report_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  perf_uart_reporter_if.slave   bus,
  output logic                  tx
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  typedef logic [BW-1:0] baud_t;
  localparam baud_t BAUD_LAST = baud_t'(CLKS_PER_BIT - 1);

  tx_state_e  state_q, state_d;
  baud_t      baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic       tx_q, tx_d;
  logic       bit_end;

  assign bit_end   = (baud_q == BAUD_LAST);
  assign bus.ready = (state_q == IDLE) || ((state_q == STOP) && bit_end);
  assign tx        = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = (state_q == IDLE || bit_end) ? '0 : baud_q + baud_t'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        if (bus.valid) begin
          state_d = START;
          sh_d    = bus.data;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = sh_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'(BITS_PER_BYTE - 1)) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
            tx_d  = sh_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bus.valid) begin
            state_d = START;
            sh_d    = bus.data;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/perf_uart_reporter.sv
// perf_uart_reporter: on a trigger, snapshots the cycle and retired-instruction
// counters and sends them as a 9-byte UART frame: A5, cycle_count LSB first,
// instr_retired LSB first.
//   clk, rst      : clock, synchronous active-high reset
//   cycle_count   : core cycle counter
//   instr_retired : core retired-instruction counter
//   trigger       : one-cycle report request, accepted only while busy=0
//   tx            : serial line, idles high
//   busy          : frame in transmission
//   done          : one-cycle pulse after the final stop bit
//   overrun       : sticky, set by a trigger seen while busy
module perf_uart_reporter
  import perf_report_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cycle_count,
  input  logic [31:0] instr_retired,
  input  logic        trigger,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  perf_uart_reporter_if byte_bus ();

  logic [31:0] cyc_q, ins_q;
  logic [3:0]  idx_q;
  logic        busy_q, done_q, ovr_q;
  logic        accept;

  assign accept = trigger && !busy_q;

  // The sync byte is offered straight from the trigger so the start bit
  // begins the cycle after acceptance; later bytes come from the snapshots.
  assign byte_bus.valid = accept || (busy_q && (idx_q < 4'(FRAME_BYTES - 1)));
  assign byte_bus.data  = accept ? SYNC_BYTE
                                 : frame_byte(idx_q + 4'd1, cyc_q, ins_q);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk (clk),
    .rst (rst),
    .bus (byte_bus.slave),
    .tx  (tx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q  <= '0;
      ins_q  <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        cyc_q  <= cycle_count;
        ins_q  <= instr_retired;
        idx_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q && byte_bus.ready) begin
        if (idx_q == 4'(FRAME_BYTES - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          idx_q <= idx_q + 4'd1;
        end
      end
      if (trigger && busy_q) ovr_q <= 1'b1;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_perf_uart_reporter.sv
// tb_perf_uart_reporter: directed bench for perf_uart_reporter at CLKS_PER_BIT=4.
// Each frame is recorded cycle by cycle from the acceptance edge T and then
// decoded against hand-computed byte values and T+1 / T+360 / T+361 timing.
module tb_perf_uart_reporter;

  localparam int C = 4;
  localparam int FRAME_CYC = 90 * C;   // 360
  localparam int FULL = FRAME_CYC + 3;  // record window for a complete frame

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cycle_count;
  logic [31:0] instr_retired;
  logic        trigger;
  logic        tx, busy, done, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic tx_r   [0:399];
  logic busy_r [0:399];
  logic done_r [0:399];
  logic ovr_r  [0:399];

  always #5 clk = ~clk;

  perf_uart_reporter #(.CLKS_PER_BIT(C)) dut (
    .clk           (clk),
    .rst           (rst),
    .cycle_count   (cycle_count),
    .instr_retired (instr_retired),
    .trigger       (trigger),
    .tx            (tx),
    .busy          (busy),
    .done          (done),
    .overrun       (overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Caller raises trigger before calling; the next posedge is T.
  // Entry c holds outputs during cycle T+c; inputs set at iteration c are
  // sampled by edge T+c.
  task automatic capture(input int len, input int chg_at, input logic [31:0] chg_val,
                         input int trig_at, input int rst_at);
    @(posedge clk);
    #1 trigger = 1'b0;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      tx_r[c]   = tx;
      busy_r[c] = busy;
      done_r[c] = done;
      ovr_r[c]  = overrun;
      rst       = (c == rst_at);
      trigger   = (c == trig_at);
      if (c == chg_at) begin
        cycle_count   = chg_val;
        instr_retired = chg_val;
      end
    end
  endtask

  task automatic check_frame(input string name, input int len,
                             input logic [31:0] ecyc, input logic [31:0] eins);
    logic [7:0] exp_b [0:8];
    logic [7:0] got;
    int ferr, nbusy, ndone, base;
    exp_b[0] = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      exp_b[1+i] = 8'(ecyc >> (8 * i));
      exp_b[5+i] = 8'(eins >> (8 * i));
    end
    ferr = 0;
    check_eq({name, "_start_at_T1"}, 32'(tx_r[1]), 32'd0);
    for (int b = 0; b < 9; b++) begin
      got = '0;
      for (int k = 0; k < 10; k++) begin
        base = 1 + (b * 10 + k) * C;
        for (int j = 1; j < C; j++)
          if (tx_r[base+j] !== tx_r[base]) ferr++;
        if (k == 0 && tx_r[base] !== 1'b0) ferr++;
        if (k == 9 && tx_r[base] !== 1'b1) ferr++;
        if (k >= 1 && k <= 8) got[k-1] = tx_r[base];
      end
      check_eq($sformatf("%s_byte%0d", name, b), 32'(got), 32'(exp_b[b]));
    end
    check_eq({name, "_framing_errors"}, 32'(ferr), 32'd0);
    nbusy = 0;
    for (int c = 1; c <= FRAME_CYC; c++) if (busy_r[c] === 1'b1) nbusy++;
    check_eq({name, "_busy_cycles"}, 32'(nbusy), 32'(FRAME_CYC));
    check_eq({name, "_busy_low_at_done"}, 32'(busy_r[FRAME_CYC+1]), 32'd0);
    check_eq({name, "_done_at_T361"}, 32'(done_r[FRAME_CYC+1]), 32'd1);
    check_eq({name, "_tx_high_at_done"}, 32'(tx_r[FRAME_CYC+1]), 32'd1);
    ndone = 0;
    for (int c = 1; c <= len; c++) if (done_r[c] === 1'b1) ndone++;
    check_eq({name, "_done_pulses"}, 32'(ndone), 32'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int ndone;
    // Reset held together with trigger: reset must win, no frame.
    rst = 1'b1;
    trigger = 1'b1;
    cycle_count = 32'h0;
    instr_retired = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    trigger = 1'b0;
    @(negedge clk);
    check_eq("reset_tx", 32'(tx), 32'd1);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_overrun", 32'(overrun), 32'd0);

    // Basic frame.
    cycle_count = 32'h12345678;
    instr_retired = 32'h0000ABCD;
    trigger = 1'b1;
    capture(FULL, 0, '0, 0, 0);
    check_frame("basic", FULL, 32'h12345678, 32'h0000ABCD);
    check_eq("basic_no_overrun", 32'(ovr_r[FULL]), 32'd0);

    // Snapshot isolation: inputs change at T+5.
    cycle_count = 32'h11223344;
    instr_retired = 32'h55667788;
    trigger = 1'b1;
    capture(FULL, 5, 32'hFFFFFFFF, 0, 0);
    check_frame("snap", FULL, 32'h11223344, 32'h55667788);

    // Overrun: second trigger at T+50 is ignored but flagged.
    cycle_count = 32'h12345678;
    instr_retired = 32'h0000ABCD;
    trigger = 1'b1;
    capture(FULL, 0, '0, 50, 0);
    check_frame("ovr", FULL, 32'h12345678, 32'h0000ABCD);
    check_eq("ovr_clear_at_T50", 32'(ovr_r[50]), 32'd0);
    check_eq("ovr_set_at_T51", 32'(ovr_r[51]), 32'd1);
    check_eq("ovr_sticky", 32'(ovr_r[FULL]), 32'd1);
    pulse_reset();
    @(negedge clk);
    check_eq("ovr_cleared_by_reset", 32'(overrun), 32'd0);

    // Back-to-back: trigger in the done cycle (T+361); inputs for the second
    // frame change at T+200, after the first snapshot.
    cycle_count = 32'hDEADBEEF;
    instr_retired = 32'h00000001;
    trigger = 1'b1;
    capture(FRAME_CYC + 1, 200, 32'h0BADF00D, FRAME_CYC + 1, 0);
    check_frame("b2b_a", FRAME_CYC + 1, 32'hDEADBEEF, 32'h00000001);
    capture(FULL, 0, '0, 0, 0);
    check_frame("b2b_b", FULL, 32'h0BADF00D, 32'h0BADF00D);
    check_eq("b2b_no_overrun", 32'(ovr_r[FULL]), 32'd0);

    // Reset at T+100, new trigger at T+105 with new inputs set at T+103.
    cycle_count = 32'h12345678;
    instr_retired = 32'h0000ABCD;
    trigger = 1'b1;
    capture(105, 103, 32'h600DCAFE, 105, 100);
    for (int c = 101; c <= 105; c++) begin
      check_eq($sformatf("mrst_tx_T%0d", c), 32'(tx_r[c]), 32'd1);
      check_eq($sformatf("mrst_busy_T%0d", c), 32'(busy_r[c]), 32'd0);
      check_eq($sformatf("mrst_ovr_T%0d", c), 32'(ovr_r[c]), 32'd0);
    end
    ndone = 0;
    for (int c = 1; c <= 105; c++) if (done_r[c] === 1'b1) ndone++;
    check_eq("mrst_no_done", 32'(ndone), 32'd0);
    capture(FULL, 0, '0, 0, 0);
    check_frame("mrst_after", FULL, 32'h600DCAFE, 32'h600DCAFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
